addsub_arbiter: RTL and testbench



---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_core.sv | 54 +++++
 rtl/addsub_arbiter.sv | 139 +++++++++++++
 tb/tb_addsub_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the add/sub arbiter slice
// Contents: ADDSUB_WIDTH default operand width, op_t opcode enum, state_t FSM enum.

package addsub_pkg;

  localparam int ADDSUB_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_UADD = 2'b00,
    OP_USUB = 2'b01,
    OP_SADD = 2'b10,
    OP_SSUB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/addsub_core.sv
// rtl/addsub_core.sv - combinational add/sub unit with carry, borrow and signed overflow
// Ports: a_i, b_i operands; op_i opcode; res_o result modulo 2^WIDTH; ovf_o overflow/borrow flag.

module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_t              op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o
);

  // One extra bit captures carry out of the add and borrow out of the subtract.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           a_msb;
  logic           b_msb;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign a_msb = a_i[WIDTH-1];
  assign b_msb = b_i[WIDTH-1];

  always_comb begin
    res_o = sum[WIDTH-1:0];
    ovf_o = 1'b0;
    case (op_i)
      OP_UADD: begin
        res_o = sum[WIDTH-1:0];
        ovf_o = sum[WIDTH];
      end
      OP_USUB: begin
        res_o = diff[WIDTH-1:0];
        ovf_o = diff[WIDTH];
      end
      OP_SADD: begin
        res_o = sum[WIDTH-1:0];
        ovf_o = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      OP_SSUB: begin
        res_o = diff[WIDTH-1:0];
        ovf_o = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
      end
      default: begin
        res_o = sum[WIDTH-1:0];
        ovf_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin sharing of one add/sub core between two requesters
// Ports: clk, rst_n (async active-low); req0_*/req1_* valid/ready request ports with a, b, op;
//        rsp_valid/rsp_ready response handshake with rsp_id, rsp_res, rsp_ovf; busy = not IDLE.

module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_ovf,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  op_t              op_q, op_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             grant_id;
  logic [WIDTH-1:0] core_res;
  logic             core_ovf;

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .res_o (core_res),
    .ovf_o (core_ovf)
  );

  // A lone requester always wins; rr_ptr only breaks ties.
  assign grant_id = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_ovf_d   = rsp_ovf_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is only offered to a valid requester, so ready implies handshake.
        if (req0_valid || req1_valid) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          a_d        = grant_id ? req1_a : req0_a;
          b_d        = grant_id ? req1_b : req0_b;
          op_d       = op_t'(grant_id ? req1_op : req0_op);
          id_d       = grant_id;
          rr_ptr_d   = ~grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_res_d   = core_res;
        rsp_ovf_d   = core_ovf;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // Only the valid flag drops; result fields hold their last values.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_UADD;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed self-checking bench for addsub_arbiter

module tb_addsub_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic [1:0]   req0_op;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [1:0]   req1_op;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
  logic [W-1:0] rsp_res;

  int checks   = 0;
  int failures = 0;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_res    (rsp_res),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  // Called at a falling edge; returns 1ns after the falling edge where a ready is seen.
  task automatic wait_grant(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_grant"}, {31'b0, got}, 32'd1);
  endtask

  // Full transaction with rsp_ready high; starts and ends at a falling edge in IDLE.
  task automatic run_op(input string tag, input int id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] op,
                        input logic [W-1:0] exp_res, input logic exp_ovf);
    set_req(id, a, b, op);
    wait_grant(tag);
    check_eq({tag, "_ready"}, {31'b0, (id == 0) ? req0_ready : req1_ready}, 32'd1);
    @(negedge clk);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    check_eq({tag, "_exec_valid"}, {31'b0, rsp_valid}, 32'd0);
    check_eq({tag, "_exec_busy"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    check_eq({tag, "_res"}, {28'b0, rsp_res}, {28'b0, exp_res});
    check_eq({tag, "_ovf"}, {31'b0, rsp_ovf}, {31'b0, exp_ovf});
    check_eq({tag, "_id"}, {31'b0, rsp_id}, id);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_res", {28'b0, rsp_res}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_rsp_id", {31'b0, rsp_id}, 32'd0);
    check_eq("idle_rsp_ovf", {31'b0, rsp_ovf}, 32'd0);
    check_eq("idle_no_ready", {30'b0, req1_ready, req0_ready}, 32'd0);

    // Opcode vectors.
    run_op("sadd_ovf",  0, 4'b0111, 4'b0001, 2'b10, 4'b1000, 1'b1);
    run_op("ssub_ovf",  1, 4'b1000, 4'b0001, 2'b11, 4'b0111, 1'b1);
    run_op("usub_brw",  1, 4'b0011, 4'b0101, 2'b01, 4'b1110, 1'b1);
    run_op("uadd_cry",  1, 4'b1111, 4'b0001, 2'b00, 4'b0000, 1'b1);
    run_op("uadd_ok",   0, 4'b0011, 4'b0100, 2'b00, 4'b0111, 1'b0);
    run_op("sadd_ok",   0, 4'b0101, 4'b1110, 2'b10, 4'b0011, 1'b0);
    run_op("ssub_ok",   1, 4'b0000, 4'b0001, 2'b11, 4'b1111, 1'b0);

    // Round-robin with both requesters held valid from reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 4'd1, 4'd2, 2'b00);
    set_req(1, 4'd5, 4'd3, 2'b01);
    for (int k = 0; k < 4; k++) begin
      wait_grant("rr");
      check_eq("rr_grant_id", {30'b0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      @(negedge clk);
      check_eq("rr_rsp_id", {31'b0, rsp_id}, k % 2);
      check_eq("rr_rsp_res", {28'b0, rsp_res}, (k % 2 == 0) ? 32'd3 : 32'd2);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Backpressure on the response, operand change after handshake, waiting requester.
    rsp_ready = 1'b0;
    set_req(0, 4'd2, 4'd3, 2'b00);
    wait_grant("hold");
    @(negedge clk);
    req0_valid = 1'b0; req0_a = 4'd15; req0_b = 4'd15;
    set_req(1, 4'd1, 4'd1, 2'b00);
    #1;
    check_eq("hold_exec_r1rdy", {31'b0, req1_ready}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check_eq("hold_res", {28'b0, rsp_res}, 32'd5);
      check_eq("hold_ovf", {31'b0, rsp_ovf}, 32'd0);
      check_eq("hold_id", {31'b0, rsp_id}, 32'd0);
      check_eq("hold_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("release_r1rdy", {31'b0, req1_ready}, 32'd0);
    @(negedge clk);
    #1;
    check_eq("regrant_r1rdy", {31'b0, req1_ready}, 32'd1);
    check_eq("regrant_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("regrant_res_kept", {28'b0, rsp_res}, 32'd5);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("regrant_rsp_res", {28'b0, rsp_res}, 32'd2);
    check_eq("regrant_rsp_id", {31'b0, rsp_id}, 32'd1);
    @(negedge clk);

    // Reset during EXEC discards the op and restores requester-0 preference.
    run_op("pre_rst", 0, 4'd7, 4'd1, 2'b00, 4'd8, 1'b0);
    set_req(0, 4'd3, 4'd3, 2'b00);
    wait_grant("rst_exec");
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rstx_busy", {31'b0, busy}, 32'd0);
    check_eq("rstx_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rstx_res", {28'b0, rsp_res}, 32'd0);
    check_eq("rstx_id_ovf", {30'b0, rsp_id, rsp_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rstx_no_rsp", {30'b0, busy, rsp_valid}, 32'd0);
    end
    set_req(0, 4'd1, 4'd1, 2'b00);
    set_req(1, 4'd1, 4'd1, 2'b00);
    #1;
    check_eq("rstx_grant0", {30'b0, req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
